// File: rtl/lorenz_pkg.sv
// Shared definitions for the Lorenz drive-response receiver.
// Holds the default word/fraction widths, the FSM state type and the
// indices of the eight products computed by the shared multiplier.
package lorenz_pkg;

  localparam int DATA_W_DEF = 27;
  localparam int FRAC_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_UPD  = 2'd2
  } state_t;

  // Product schedule. Terms that depend on an earlier product come after it.
  localparam logic [2:0] STEP_DT_DYX   = 3'd0;  // dt*(Yr-Xr)
  localparam logic [2:0] STEP_DX       = 3'd1;  // (dt*(Yr-Xr))*sigma
  localparam logic [2:0] STEP_SDT      = 3'd2;  // s*dt
  localparam logic [2:0] STEP_SDT_RZ   = 3'd3;  // (s*dt)*(rho-Zr)
  localparam logic [2:0] STEP_YDT      = 3'd4;  // Yr*dt
  localparam logic [2:0] STEP_SDT_Y    = 3'd5;  // (s*dt)*Yr
  localparam logic [2:0] STEP_DTZ      = 3'd6;  // dt*Zr
  localparam logic [2:0] STEP_DTZ_BETA = 3'd7;  // (dt*Zr)*beta
  localparam logic [2:0] STEP_LAST     = STEP_DTZ_BETA;

endpackage

// File: rtl/lorenz_receiver_if.sv
// Stream bundle for the receiver: drive samples in (s_*), recovered
// message out (m_*).
// Handshake: a word moves on a rising edge where valid and ready are both
// high; a source holds valid and data steady until that edge, and ready
// may depend combinationally on the opposite side's ready.
//   master : drives s_in/s_valid and m_ready
//   slave  : drives s_ready and m_out/m_valid
interface lorenz_receiver_if
  import lorenz_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic signed [DATA_W-1:0] s_in;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] m_out;
  logic                     m_valid;
  logic                     m_ready;

  modport master (output s_in, s_valid, m_ready, input s_ready, m_out, m_valid);
  modport slave  (input s_in, s_valid, m_ready, output s_ready, m_out, m_valid);
endinterface

// File: rtl/signed_mult.sv
// Fixed-point signed multiplier (combinational).
//   a, b : signed DATA_W operands, FRAC_W fraction bits
//   p    : full 2*DATA_W product shifted right by FRAC_W and kept to
//          DATA_W bits (floor rounding, upper bits wrap)
module signed_mult #(
  parameter int DATA_W = 27,
  parameter int FRAC_W = 20
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] p
);
  logic signed [2*DATA_W-1:0] full;
  logic                       unused_bits;

  assign full = a * b;
  assign p    = full[DATA_W+FRAC_W-1:FRAC_W];
  // Discarded fraction and overflow bits.
  assign unused_bits = ^{full[2*DATA_W-1:DATA_W+FRAC_W], full[FRAC_W-1:0]};
endmodule

// File: rtl/lorenz_receiver.sv
// Lorenz drive-response receiver.
// Each accepted drive sample s produces m_out = s - Xr (state before the
// step) and then one Euler step of the receiver driven by s. The eight
// products of the step go through one shared multiplier, one per cycle.
//   clk, reset          : clock, synchronous active-high reset
//   dt,sigma,beta,rho   : static coefficients
//   X0,Y0,Z0            : initial / resync state
//   resync              : reload state from X0/Y0/Z0 (IDLE only)
//   bus (slave)         : s_in/s_valid/s_ready, m_out/m_valid/m_ready
//   Xr,Yr,Zr            : current receiver state
//   dbg_state, dbg_step : FSM state and multiplier step
module lorenz_receiver
  import lorenz_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] dt,
  input  logic signed [DATA_W-1:0] sigma,
  input  logic signed [DATA_W-1:0] beta,
  input  logic signed [DATA_W-1:0] rho,
  input  logic signed [DATA_W-1:0] X0,
  input  logic signed [DATA_W-1:0] Y0,
  input  logic signed [DATA_W-1:0] Z0,
  input  logic                     resync,
  lorenz_receiver_if.slave         bus,
  output logic signed [DATA_W-1:0] Xr,
  output logic signed [DATA_W-1:0] Yr,
  output logic signed [DATA_W-1:0] Zr,
  output state_t                   dbg_state,
  output logic [2:0]               dbg_step
);
  typedef logic signed [DATA_W-1:0] word_t;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  word_t      s_q;
  word_t      m_out_q;
  logic       m_valid_q;
  word_t      prod_q [8];
  word_t      mul_a, mul_b, mul_p;
  word_t      diff_yx, diff_rz;
  logic       accept;

  assign diff_yx = Yr - Xr;
  assign diff_rz = rho - Zr;

  // A new sample is taken only in IDLE, only when the result slot is free
  // (or draining this edge), and never while a resync is requested.
  assign bus.s_ready = (state_q == ST_IDLE) && (!m_valid_q || bus.m_ready) && !resync;
  assign accept      = bus.s_valid && bus.s_ready;
  assign bus.m_out   = m_out_q;
  assign bus.m_valid = m_valid_q;
  assign dbg_state   = state_q;
  assign dbg_step    = step_q;

  // Operand selection for the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (step_q)
      STEP_DT_DYX:   begin mul_a = dt;                 mul_b = diff_yx; end
      STEP_DX:       begin mul_a = prod_q[STEP_DT_DYX]; mul_b = sigma;   end
      STEP_SDT:      begin mul_a = s_q;                mul_b = dt;      end
      STEP_SDT_RZ:   begin mul_a = prod_q[STEP_SDT];   mul_b = diff_rz; end
      STEP_YDT:      begin mul_a = Yr;                 mul_b = dt;      end
      STEP_SDT_Y:    begin mul_a = prod_q[STEP_SDT];   mul_b = Yr;      end
      STEP_DTZ:      begin mul_a = dt;                 mul_b = Zr;      end
      STEP_DTZ_BETA: begin mul_a = prod_q[STEP_DTZ];   mul_b = beta;    end
      default:       begin mul_a = '0;                 mul_b = '0;      end
    endcase
  end

  signed_mult #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_mult (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_MUL;
          step_d  = 3'd0;
        end
      end
      ST_MUL: begin
        if (step_q == STEP_LAST) begin
          state_d = ST_UPD;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ST_UPD: begin
        state_d = ST_IDLE;
        step_d  = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Xr        <= X0;
      Yr        <= Y0;
      Zr        <= Z0;
      s_q       <= '0;
      m_out_q   <= '0;
      m_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) prod_q[i] <= '0;
    end else begin
      // A same-edge acceptance reloads the result slot instead of clearing it.
      if (accept) begin
        s_q       <= bus.s_in;
        m_out_q   <= bus.s_in - Xr;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (state_q == ST_MUL) prod_q[step_q] <= mul_p;

      // All three coordinates commit together from pre-step values.
      if (state_q == ST_UPD) begin
        Xr <= Xr + prod_q[STEP_DX];
        Yr <= Yr + prod_q[STEP_SDT_RZ] - prod_q[STEP_YDT];
        Zr <= Zr + prod_q[STEP_SDT_Y] - prod_q[STEP_DTZ_BETA];
      end else if (state_q == ST_IDLE && resync) begin
        Xr <= X0;
        Yr <= Y0;
        Zr <= Z0;
      end
    end
  end

endmodule

// File: doc/lorenz_receiver.md
LORENZ_RECEIVER -- requirements
Module: lorenz_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 27, signed sample/state width.
REQ-002 SHALL have parameter FRAC_W, default 20, fraction bits (Q6.20 plus sign).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 dt, sigma, beta, rho  in  DATA_W each  signed Lorenz coefficients, held static.
REQ-007 X0, Y0, Z0  in  DATA_W each  signed receiver initial state.
REQ-008 resync  in  1  reload receiver state from X0/Y0/Z0.
REQ-009 s_in  in  DATA_W  received drive sample s = x_tx + m.
REQ-010 s_valid  in  1 / s_ready  out  1  input handshake; transfer when both high.
REQ-011 m_out  out  DATA_W  recovered message m_hat.
REQ-012 m_valid  out  1 / m_ready  in  1  output handshake; transfer when both high.
REQ-013 Xr, Yr, Zr  out  DATA_W each  current receiver state.

Function
REQ-014 Receiver SHALL implement drive-response Euler step per accepted s: Xr += (dt*(Yr-Xr))*sigma; Yr += (s*dt)*(rho-Zr) - Yr*dt; Zr += (s*dt)*Yr - (dt*Zr)*beta.
REQ-015 Every product SHALL be full 2*DATA_W signed, result = bits [DATA_W+FRAC_W-1:FRAC_W] (arithmetic truncation toward -inf); add/sub wrap two's complement, no saturation.
REQ-016 Multiplication order SHALL be exactly as in REQ-014 so a matched transmitter is bit-exact.
REQ-017 One shared multiplier SHALL be used, time-multiplexed: eight products, one per cycle.
REQ-018 FSM states: IDLE, MUL (3-bit step counter 0..7), UPD.
REQ-019 s_ready SHALL equal (state==IDLE) && (!m_valid || m_ready) && !resync.
REQ-020 On acceptance edge E0: latch s, register m_out = s - Xr (pre-update state), set m_valid, go to MUL step 0.
REQ-021 Edges E1..E8 SHALL each register one product; E9 (UPD) commits Xr/Yr/Zr simultaneously and returns to IDLE; next acceptance earliest at E10.
REQ-022 m_valid SHALL stay high with m_out stable until m_ready; clears on transfer unless a new acceptance occurs the same edge (then reloads).
REQ-023 resync SHALL act only in IDLE: Xr/Yr/Zr <= X0/Y0/Z0 next edge, no acceptance that cycle; ignored in MUL/UPD; does not affect m_valid/m_out.
REQ-024 Coefficient or X0/Y0/Z0 changes during MUL/UPD SHALL give undefined step result; no protection required.

Reset
REQ-025 On reset: state IDLE, step 0, Xr/Yr/Zr = X0/Y0/Z0, m_out 0, m_valid 0, product registers 0.
REQ-026 Reset SHALL override any state, including mid-MUL; s_ready high in the first cycle after reset deasserts.

Structure
REQ-027 Shared package lorenz_pkg SHALL hold DATA_W, FRAC_W defaults, FSM state enum, step-index constants.
REQ-028 Exactly one signed_mult instance SHALL be the sole sub-module; muxing and FSM in lorenz_receiver.

Verification (dt=0x1000 [1/256], sigma=0xA00000 [10], beta=0x2AAAAA, rho=0x1C00000 [28], X0=-1048576, Y0=104858, Z0=26214400)
REQ-029 Reset -> Xr=-1048576, Yr=104858, Zr=26214400, m_valid=0, s_ready=1.
REQ-030 One sample s=-1048576, m_ready=1 -> m_out=0 one edge later; after E9 Xr=-1003526; s_ready high again at E10.
REQ-031 m_ready=0, two back-to-back samples -> m_valid held, m_out constant, second sample not accepted until m_ready pulses.
REQ-032 Reset asserted at MUL step 4 -> next cycle all REQ-025 values; resync asserted during MUL -> no effect; in IDLE -> state equals X0/Y0/Z0.
REQ-033 Bit-exact transmitter model, same coefficients/init, m=0, 1000 samples -> m_out=0 every sample, Xr/Yr/Zr match transmitter.
REQ-034 Same as REQ-033 with constant m=524288 (0.5) -> first m_out=524288 exactly.
